// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 5-digit 7-segment driver for packed BCD input.
// Includes leading-zero blanking, a dash for invalid nibbles and frame-aligned (tear-free) updates.
module seg7_scan_driver #(
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    input  logic        enable,
    output logic [4:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int            CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [4:0]    AN_OFF  = ACTIVE_LOW ? 5'h1F : 5'h00;
    localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [19:0]   shadow_q, shadow_d;
    logic [19:0]   disp_q, disp_d;
    logic          full_q, full_d;
    logic          frame_done_q, frame_done_d;
    logic [4:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic          wrap;
    logic [19:0]   disp_shift;
    logic [3:0]    nib;
    logic [4:0]    lz;
    logic          blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
    always_comb begin
        tick = (cnt_q == CNT_MAX);
        wrap = tick && (idx_q == 3'd4);

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end

        // Capture requires ~full and transfer requires full, so the two branches are exclusive.
        shadow_d = shadow_q;
        full_d   = full_q;
        disp_d   = disp_q;
        if (wrap && full_q) begin
            disp_d = shadow_q;
            full_d = 1'b0;
        end else if (bcd_valid && !full_q) begin
            shadow_d = bcd_in;
            full_d   = 1'b1;
        end
        frame_done_d = wrap;

        disp_shift = disp_q >> {idx_q, 2'b00};
        nib        = disp_shift[3:0];

        // lz[i]: digit i and every higher digit are zero; A..F counts as nonzero.
        lz[4] = (disp_q[19:16] == 4'd0);
        lz[3] = lz[4] && (disp_q[15:12] == 4'd0);
        lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
        lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
        lz[0] = 1'b0;
        blank = BLANK_LZ && lz[idx_q];

        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (enable && !blank) begin
            an_d  = (5'b00001 << idx_q) ^ AN_OFF;
            seg_d = decode(nib) ^ SEG_OFF;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= 20'h0;
            disp_q       <= 20'h0;
            full_q       <= 1'b0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            full_q       <= full_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign bcd_ready  = ~full_q;
    assign frame_done = frame_done_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle-count based display model checked every cycle against an
// active-high and an active-low instance, plus directed cases with literal expectations.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bcd_valid = 1'b0;
    logic        enable = 1'b1;
    logic [19:0] bcd_in = 20'h0;

    logic        rdy_h, fd_h, rdy_l, fd_l;
    logic [4:0]  an_h, an_l;
    logic [6:0]  seg_h, seg_l;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(2), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut_h (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .bcd_ready(rdy_h),
        .enable(enable), .an(an_h), .seg(seg_h), .frame_done(fd_h)
    );

    seg7_scan_driver #(.SCAN_DIV(2), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .bcd_ready(rdy_l),
        .enable(enable), .an(an_l), .seg(seg_l), .frame_done(fd_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Digit slot is derived purely from elapsed cycles since reset: 2 cycles per digit, 10 per frame.
    logic [6:0] seg_tbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    int unsigned m_cyc;
    logic        m_full;
    logic [19:0] m_shadow, m_disp;
    logic [4:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fd;
    logic        model_ok = 1'b0;

    function automatic int slot(input int unsigned c);
        return int'((c / 2) % 5);
    endfunction

    function automatic logic shown(input logic [19:0] v, input int i, input logic en);
        // Digit i (i>=1) is blank when the value has no nonzero digit at position i or above.
        return en && !((i > 0) && (int'(v) < (16 ** i)));
    endfunction

    function automatic logic [4:0] exp_an(input logic [19:0] v, input int i, input logic en);
        return shown(v, i, en) ? 5'(1 << i) : 5'h00;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [19:0] v, input int i, input logic en);
        return shown(v, i, en) ? seg_tbl[(int'(v) >> (4 * i)) % 16] : 7'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_ok <= 1'b1;
            m_cyc    <= 0;
            m_full   <= 1'b0;
            m_shadow <= 20'h0;
            m_disp   <= 20'h0;
            e_an     <= 5'h00;
            e_seg    <= 7'h00;
            e_fd     <= 1'b0;
        end else begin
            e_an  <= exp_an(m_disp, slot(m_cyc), enable);
            e_seg <= exp_seg(m_disp, slot(m_cyc), enable);
            e_fd  <= (m_cyc % 10 == 9);
            if ((m_cyc % 10 == 9) && m_full) begin
                m_disp <= m_shadow;
                m_full <= 1'b0;
            end else if (bcd_valid && !m_full) begin
                m_shadow <= bcd_in;
                m_full   <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("an", an_h, e_an);
            check("seg", seg_h, e_seg);
            check("frame_done", fd_h, e_fd);
            check("bcd_ready", rdy_h, !m_full);
            check("an_l", an_l, 5'(~e_an));
            check("seg_l", seg_l, 7'(~e_seg));
            check("frame_done_l", fd_l, e_fd);
            check("bcd_ready_l", rdy_l, !m_full);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_digit(input int i, input logic [6:0] exp, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            found = (an_h == 5'(1 << i));
        end
        if (!found) check({name, "_timeout"}, 0, 1);
        else begin
            check(name, seg_h, exp);
            check({name, "_l"}, seg_l, 7'(~exp));
        end
    endtask

    task automatic wait_fd(input string name);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            found = fd_h;
        end
        if (!found) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic observe(input int n, output logic [4:0] an_or, output logic [6:0] seg_or,
                           output int pulses, output int gap);
        int last = -1;
        an_or  = 5'h00;
        seg_or = 7'h00;
        pulses = 0;
        gap    = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            an_or  = an_or | an_h;
            seg_or = seg_or | seg_h;
            if (fd_h) begin
                if (last >= 0) gap = k - last;
                last = k;
                pulses++;
            end
        end
    endtask

    task automatic load(input logic [19:0] v, input string name);
        bcd_in    = v;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        check({name, "_ready_low"}, rdy_h, 1'b0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [4:0] an_or;
        logic [6:0] seg_or;
        int pulses, gap;

        // 1. reset and idle zero display
        repeat (2) @(negedge clk);
        check("rst_an", an_h, 5'h00);
        check("rst_seg", seg_h, 7'h00);
        check("rst_ready", rdy_h, 1'b1);
        check("rst_fd", fd_h, 1'b0);
        check("rst_an_l", an_l, 5'h1F);
        check("rst_seg_l", seg_l, 7'h7F);
        rst = 1'b0;
        observe(20, an_or, seg_or, pulses, gap);
        check("idle_an_or", an_or, 5'h01);
        check("idle_seg_or", seg_or, 7'h3F);
        wait_digit(0, 7'h3F, "idle_d0");

        // 2. 65233
        load(20'h65233, "t2");
        wait_fd("t2_fd");
        check("t2_ready_after_fd", rdy_h, 1'b1);
        wait_digit(0, 7'h4F, "t2_d0");
        wait_digit(1, 7'h4F, "t2_d1");
        wait_digit(2, 7'h5B, "t2_d2");
        wait_digit(3, 7'h6D, "t2_d3");
        wait_digit(4, 7'h7D, "t2_d4");

        // 3. 00042 with leading zeros blanked
        load(20'h00042, "t3");
        wait_fd("t3_fd");
        observe(12, an_or, seg_or, pulses, gap);
        check("t3_an_hi_blank", an_or & 5'b11100, 5'h00);
        wait_digit(1, 7'h66, "t3_d1");
        wait_digit(0, 7'h5B, "t3_d0");

        // 4. second valid while full is ignored
        load(20'h00001, "t4");
        bcd_in    = 20'h00009;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        wait_fd("t4_fd");
        wait_digit(0, 7'h06, "t4_d0");
        observe(12, an_or, seg_or, pulses, gap);
        check("t4_ready", rdy_h, 1'b1);
        check("t4_seg_or", seg_or, 7'h06);

        // 5. invalid nibble shows a dash and keeps lower zeros visible
        load(20'h0C000, "t5");
        wait_fd("t5_fd");
        wait_digit(3, 7'h40, "t5_d3");
        wait_digit(2, 7'h3F, "t5_d2");
        wait_digit(1, 7'h3F, "t5_d1");
        wait_digit(0, 7'h3F, "t5_d0");
        observe(12, an_or, seg_or, pulses, gap);
        check("t5_d4_blank", an_or & 5'b10000, 5'h00);

        // disable: outputs dark, frame_done keeps its 10-cycle cadence
        enable = 1'b0;
        @(negedge clk);
        check("dis_an", an_h, 5'h00);
        check("dis_an_l", an_l, 5'h1F);
        observe(20, an_or, seg_or, pulses, gap);
        check("dis_an_or", an_or, 5'h00);
        check("dis_seg_or", seg_or, 7'h00);
        check("dis_pulses", pulses, 2);
        check("dis_gap", gap, 10);
        enable = 1'b1;
        wait_digit(3, 7'h40, "en_d3");

        // 6. reset with a pending shadow value
        load(20'h12345, "t6");
        rst = 1'b1;
        @(negedge clk);
        check("t6_ready", rdy_h, 1'b1);
        check("t6_an", an_h, 5'h00);
        check("t6_seg", seg_h, 7'h00);
        rst = 1'b0;
        observe(30, an_or, seg_or, pulses, gap);
        check("t6_an_or", an_or, 5'h01);
        check("t6_seg_or", seg_or, 7'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
